hazard_scoreboard_unit: RTL and testbench

Parametrised successor to the pipeline's hazard detection logic: decides Stall and Flush for the IF/ID boundary of the pipelined MIPS core. Instead of comparing only against the instruction in EX, it keeps a per-register latency scoreboard, so loads with multi-cycle memory latency are handled. It also tracks a multi-cycle multiply/divide unit (MDU) and counts stall cycles for performance reporting. Sits beside the ID stage; its outputs gate the PC / IF-ID register write enables and the ID-EX bubble insertion.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_down_counter.sv | 36 +++
 rtl/hazard_scoreboard_unit.sv | 92 +++++++++
 tb/tb_hazard_scoreboard_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: register-zero index, default index width,
// stall-reason codes for debug probes, and a counter-width helper.
package hazard_pkg;

   localparam int unsigned RADDR_W_DEF = 5;
   localparam int unsigned ZERO_REG    = 0;

   localparam logic [1:0] HZ_NONE = 2'd0;
   localparam logic [1:0] HZ_DATA = 2'd1;
   localparam logic [1:0] HZ_MDU  = 2'd2;

   // Width needed to hold a countdown value of lat; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned lat);
      return (lat < 2) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hazard_down_counter.sv
// Load-value, decrement-to-zero counter with a nonzero flag; one per scoreboard entry
// and one for the MDU busy timer.
module hazard_down_counter #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         nz_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // A load takes priority over the free-running decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign nz_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// IF/ID hazard unit: per-register load-latency scoreboard, MDU busy timer,
// stall/flush generation and a saturating stall-cycle counter.
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned NREG     = 32,
   parameter int unsigned RADDR_W  = $clog2(NREG),
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned MDU_LAT  = 4,
   parameter int unsigned PERF_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               issueValidD,
   input  logic [RADDR_W-1:0] rsD,
   input  logic [RADDR_W-1:0] rtD,
   input  logic               useRsD,
   input  logic               useRtD,
   input  logic [RADDR_W-1:0] writeRegD,
   input  logic               regWriteD,
   input  logic               memReadD,
   input  logic               mduStartD,
   input  logic               hiloReadD,
   input  logic               takenBranch,
   input  logic               pcSrc,
   output logic               Stall,
   output logic               Flush,
   output logic               mduBusy,
   output logic [PERF_W-1:0]  stallCount
);

   localparam int unsigned LCNT_W = cnt_width(LOAD_LAT);
   localparam int unsigned MCNT_W = cnt_width(MDU_LAT);

   logic              issue;
   logic [NREG-1:0]   reg_pending;
   logic [LCNT_W-1:0] ld_val;
   logic              hz_data;
   logic              hz_mdu;
   logic [PERF_W-1:0] stall_cnt_q;
   logic [PERF_W-1:0] stall_cnt_d;

   assign issue  = issueValidD & ~Stall & ~Flush;
   // Non-load writers clear the entry: their result is forwardable next cycle.
   assign ld_val = memReadD ? LCNT_W'(LOAD_LAT) : '0;

   assign reg_pending[ZERO_REG] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_sb
      hazard_down_counter #(.W(LCNT_W)) u_cnt (
         .clk        (clk),
         .rst        (rst),
         .load_i     (issue & regWriteD & (writeRegD == RADDR_W'(r))),
         .load_val_i (ld_val),
         .nz_o       (reg_pending[r])
      );
   end

   hazard_down_counter #(.W(MCNT_W)) u_mdu (
      .clk        (clk),
      .rst        (rst),
      .load_i     (issue & mduStartD),
      .load_val_i (MCNT_W'(MDU_LAT)),
      .nz_o       (mduBusy)
   );

   assign hz_data = (useRsD & (rsD != RADDR_W'(ZERO_REG)) & reg_pending[rsD])
                  | (useRtD & (rtD != RADDR_W'(ZERO_REG)) & reg_pending[rtD]);
   assign hz_mdu  = issueValidD & (mduStartD | hiloReadD) & mduBusy;

   // A redirect squashes the ID instruction, so it must not also stall.
   assign Flush = takenBranch | pcSrc;
   assign Stall = issueValidD & (hz_data | hz_mdu) & ~Flush;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (Stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Randomized and directed bench for hazard_scoreboard_unit, checked against a
// timestamp-based reference model through an expected-response queue.
module tb_hazard_scoreboard_unit;

   localparam int unsigned NREG = 32;
   localparam int unsigned L    = 3;
   localparam int unsigned M    = 4;

   logic        clk;
   logic        rst;
   logic        issueValidD;
   logic [4:0]  rsD, rtD, writeRegD;
   logic        useRsD, useRtD, regWriteD, memReadD, mduStartD, hiloReadD;
   logic        takenBranch, pcSrc;
   logic        Stall, Flush, mduBusy;
   logic [31:0] stallCount;

   hazard_scoreboard_unit #(
      .NREG(NREG), .RADDR_W(5), .LOAD_LAT(L), .MDU_LAT(M), .PERF_W(32)
   ) dut (
      .clk(clk), .rst(rst), .issueValidD(issueValidD),
      .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
      .writeRegD(writeRegD), .regWriteD(regWriteD), .memReadD(memReadD),
      .mduStartD(mduStartD), .hiloReadD(hiloReadD),
      .takenBranch(takenBranch), .pcSrc(pcSrc),
      .Stall(Stall), .Flush(Flush), .mduBusy(mduBusy), .stallCount(stallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        busy;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model: a register is unavailable until the cycle stamped in ready_at.
   int unsigned ready_at [NREG];
   int unsigned mdu_ready;
   int unsigned cyc;
   logic [31:0] exp_cnt;
   logic        prev_stall;

   task automatic model_reset();
      for (int i = 0; i < int'(NREG); i++) ready_at[i] = 0;
      mdu_ready = 0;
      exp_cnt   = '0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("Stall",      32'(Stall),   32'(e.stall));
         check("Flush",      32'(Flush),   32'(e.flush));
         check("mduBusy",    32'(mduBusy), 32'(e.busy));
         check("stallCount", stallCount,   e.cnt);
      end
   end

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] wr,
                        input logic rw, input logic mr, input logic ms, input logic hl,
                        input logic br, input logic pc, input logic r);
      exp_t e;
      logic hzd, hzm;
      @(posedge clk);
      #1;
      cyc++;
      // Retire the effect of the cycle that just ended.
      if (rst) begin
         model_reset();
      end else begin
         if (prev_stall && exp_cnt != '1) exp_cnt = exp_cnt + 32'd1;
         if (issueValidD && !prev_stall && !(takenBranch || pcSrc)) begin
            if (regWriteD && writeRegD != 5'd0)
               ready_at[writeRegD] = memReadD ? cyc + L : 0;
            if (mduStartD) mdu_ready = cyc + M;
         end
      end
      issueValidD = v; rsD = rs; rtD = rt; useRsD = urs; useRtD = urt;
      writeRegD = wr; regWriteD = rw; memReadD = mr; mduStartD = ms; hiloReadD = hl;
      takenBranch = br; pcSrc = pc; rst = r;
      if (r) model_reset();
      hzd = (urs && rs != 5'd0 && cyc < ready_at[rs]) || (urt && rt != 5'd0 && cyc < ready_at[rt]);
      hzm = v && (ms || hl) && (cyc < mdu_ready);
      e.flush = br | pc;
      e.stall = v && (hzd || hzm) && !e.flush;
      e.busy  = (cyc < mdu_ready);
      e.cnt   = exp_cnt;
      prev_stall = e.stall;
      exp_q.push_back(e);
   endtask

   // Present one instruction and hold it until the model says it issues.
   task automatic hold_issue(input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic [4:0] wr,
                             input logic rw, input logic mr, input logic ms, input logic hl);
      int n = 0;
      do begin
         drive(1'b1, rs, rt, urs, urt, wr, rw, mr, ms, hl, 1'b0, 1'b0, 1'b0);
         n++;
      end while (prev_stall && n < 20);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic        v, urs, urt, rw, mr, ms, hl, br, pc, r;
      logic [4:0]  rs, rt, wr;
      int          waited;
      rst = 1'b1; issueValidD = 0; rsD = 0; rtD = 0; useRsD = 0; useRtD = 0;
      writeRegD = 0; regWriteD = 0; memReadD = 0; mduStartD = 0; hiloReadD = 0;
      takenBranch = 0; pcSrc = 0;
      cyc = 0; prev_stall = 1'b0;
      model_reset();
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);

      // lw $5 then dependent add
      hold_issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      hold_issue(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      // lw $5, independent, reader; lw $0 then reader of $0
      hold_issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      hold_issue(5'd2, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      hold_issue(5'd1, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      hold_issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      hold_issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      // lw $5, addi $5, reader of $5
      hold_issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      hold_issue(5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      hold_issue(5'd5, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      // div, mflo, div during busy
      hold_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      hold_issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      hold_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      hold_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(6);
      // Load-use with redirect: the squashed writer must not be recorded
      hold_issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      hold_issue(5'd11, 5'd5, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      hold_issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(6);
      // Reset mid-stall with MDU busy
      hold_issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      hold_issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);

      // Randomized traffic over a small register window to provoke collisions
      v = 0; rs = 0; rt = 0; urs = 0; urt = 0; wr = 0; rw = 0; mr = 0; ms = 0; hl = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!prev_stall) begin
            v   = ($urandom_range(0, 9) != 0);
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            urs = 1'($urandom_range(0, 1));
            urt = 1'($urandom_range(0, 1));
            wr  = 5'($urandom_range(0, 7));
            rw  = ($urandom_range(0, 3) != 0);
            mr  = ($urandom_range(0, 4) < 2);
            ms  = ($urandom_range(0, 9) == 0);
            hl  = ($urandom_range(0, 9) == 0);
         end
         br = ($urandom_range(0, 19) == 0);
         pc = ($urandom_range(0, 24) == 0);
         r  = ($urandom_range(0, 399) == 0);
         drive(v, rs, rt, urs, urt, wr, rw, mr, ms, hl, br, pc, r);
      end
      idle(2);

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
